// File: rtl/ib_lut_reconf_ctrl.sv
// ----------------------------------------------------------------------------
// ib_lut_reconf_ctrl
//
// Reload sequencer for the reconfigurable information-bottleneck LUT.
// The LUT holds RAM_DEPTH entries of QUAN_SIZE bits spread over BANK_NUM
// distributed RAM banks. The bank index is taken from the top address bits.
// A reload takes a stream of table entries over a valid/ready handshake and
// issues one bank write per accepted entry, in ascending address order.
// While the reload runs, lookups from the decoder datapath are blocked.
// Completion is reported with a one-cycle cfg_done pulse. Cancellation is
// reported with a one-cycle cfg_aborted pulse.
//
// Ports
//   sys_clk      in   clock, all state changes on the rising edge
//   rstn         in   synchronous active-low reset
//   cfg_start    in   request a full table reload (sampled in IDLE only)
//   cfg_abort    in   cancel an in-progress reload (LOAD / FLUSH only)
//   ld_data      in   next table entry
//   ld_valid     in   ld_data valid
//   ld_ready     out  entry accepted this cycle when ld_valid is high
//   wr_addr      out  registered bank write address
//   wr_data      out  registered bank write data
//   bank_we      out  registered one-hot bank write enable
//   lookup_en    in   datapath requests LUT access
//   lookup_gnt   out  datapath may use the LUT this cycle
//   lut_busy     out  reload in progress
//   cfg_done     out  one-cycle pulse, reload completed
//   cfg_aborted  out  one-cycle pulse, reload aborted
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no reload; the LUT is available to the datapath
// LOAD  | accepting entries, one bank write per accepted beat
// FLUSH | final write (last address) is on the bank outputs
// DONE  | cfg_done pulse; the LUT is released on the next edge
// ----------------------------------------------------------------------------
module ib_lut_reconf_ctrl #(
  parameter int QUAN_SIZE = 4,
  parameter int IB_ADDR   = 8,
  parameter int RAM_DEPTH = 256,
  parameter int BANK_NUM  = 8
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [QUAN_SIZE-1:0] ld_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  output logic [IB_ADDR-1:0]   wr_addr,
  output logic [QUAN_SIZE-1:0] wr_data,
  output logic [BANK_NUM-1:0]  bank_we,
  input  logic                 lookup_en,
  output logic                 lookup_gnt,
  output logic                 lut_busy,
  output logic                 cfg_done,
  output logic                 cfg_aborted
);

  localparam int CNT_W  = IB_ADDR + 1;
  localparam int BANK_W = $clog2(BANK_NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Gating ready with cfg_abort keeps the handshake honest: no beat is
  // accepted in the abort cycle, so the source must not consider it taken.
  assign ld_ready = (state == ST_LOAD) & ~cfg_abort;

  // The reload wins a same-cycle tie with a lookup request.
  assign lookup_gnt = lookup_en & (state == ST_IDLE) & ~cfg_start;

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      wr_addr     <= '0;
      wr_data     <= '0;
      bank_we     <= '0;
      lut_busy    <= 1'b0;
      cfg_done    <= 1'b0;
      cfg_aborted <= 1'b0;
    end else begin
      // Write enables and status pulses last one cycle unless re-armed below.
      bank_we     <= '0;
      cfg_done    <= 1'b0;
      cfg_aborted <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            lut_busy <= 1'b1;
          end
        end

        ST_LOAD: begin
          if (cfg_abort) begin
            state       <= ST_IDLE;
            lut_busy    <= 1'b0;
            cfg_aborted <= 1'b1;
          end else if (ld_valid) begin
            wr_addr <= cnt[IB_ADDR-1:0];
            wr_data <= ld_data;
            bank_we <= BANK_NUM'(1) << cnt[IB_ADDR-1 -: BANK_W];
            cnt     <= cnt + CNT_W'(1);
            // The terminal beat leaves LOAD, so cnt never wraps.
            if (cnt == CNT_LAST) begin
              state <= ST_FLUSH;
            end
          end
        end

        ST_FLUSH: begin
          if (cfg_abort) begin
            state       <= ST_IDLE;
            lut_busy    <= 1'b0;
            cfg_aborted <= 1'b1;
          end else begin
            state    <= ST_DONE;
            cfg_done <= 1'b1;
          end
        end

        ST_DONE: begin
          state    <= ST_IDLE;
          lut_busy <= 1'b0;
        end

        default: begin
          state    <= ST_IDLE;
          lut_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
